// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch front end.
// Imported by fetch_stage and pc_register.
package fetch_stage_pkg;

    localparam int          DEFAULT_DATA_WIDTH = 32;
    localparam logic [31:0] DEFAULT_TEXT_BASE  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam int          PC_INCREMENT       = 4;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Enabled register with parameterised reset value, used for the PC.
// Asynchronous active-low reset.
module pc_register
    import fetch_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RESET_VALUE;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, ROM addressing and the IF/ID pipeline register.
// Define FETCH_BOUNDS_CHECK_EN to squash out-of-ROM fetches and raise Fault_o.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(DEFAULT_TEXT_BASE),
    parameter int                    MEMORY_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Target_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] MemAddress_o,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] IFID_Instruction_o,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4_o,
    output logic                  IFID_Valid_o,
    output logic                  Fault_o
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);
    localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(PC_INCREMENT);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  pc_en;
    logic                  capture;
    logic                  fetch_ok;

    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pcp4_q, pcp4_d;
    logic                  valid_q, valid_d;

    assign pc_plus4 = pc_q + INC;
    assign mem_addr = pc_q - TEXT_BASE;
    assign pc_en    = Redirect_i | ~Stall_i;
    assign capture  = ~Redirect_i & ~Stall_i;
    // Low target bits are dropped so the PC is always word aligned.
    assign pc_d     = Redirect_i ? (Target_i & ~DATA_WIDTH'(3)) : pc_plus4;

    pc_register #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (TEXT_BASE)
    ) u_pc (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (pc_en),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] ROM_WORDS = DATA_WIDTH'(MEMORY_DEPTH);

    logic fault_q;

    assign fetch_ok = (pc_q >= TEXT_BASE) && ((mem_addr >> 2) < ROM_WORDS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (capture && !fetch_ok) begin
            fault_q <= 1'b1;
        end
    end

    assign Fault_o = fault_q;
`else
    assign fetch_ok = 1'b1;
    assign Fault_o  = 1'b0;
`endif

    always_comb begin
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (Redirect_i) begin
            instr_d = NOP;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end else if (capture) begin
            instr_d = fetch_ok ? Instruction_i : NOP;
            pcp4_d  = pc_plus4;
            valid_d = fetch_ok;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign MemAddress_o       = mem_addr;
    assign PC_o               = pc_q;
    assign IFID_Instruction_o = instr_q;
    assign IFID_PCPlus4_o     = pcp4_q;
    assign IFID_Valid_o       = valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end. Holds the program counter and drives the byte address into the combinational program ROM.
- Captures the returned instruction into the IF/ID pipeline register.
- Accepts stall from the hazard unit and redirect (branch/jump target) from the decode/execute stages.
- Sits directly upstream of the ROM and feeds the decode stage.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction words.
- TEXT_BASE, 32'h0040_0000, byte address of ROM word 0; also the PC reset value.
- MEMORY_DEPTH, 32, ROM depth in words; used only by the optional bounds check.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Stall_i  input  1  hold PC and IF/ID contents.
- Redirect_i  input  1  load Target_i into PC and squash the IF/ID entry.
- Target_i  input  DATA_WIDTH  redirect byte address.
- Instruction_i  input  DATA_WIDTH  ROM read data for MemAddress_o (combinational, same cycle).
- MemAddress_o  output  DATA_WIDTH  PC - TEXT_BASE, byte offset into ROM.
- PC_o  output  DATA_WIDTH  current PC.
- IFID_Instruction_o  output  DATA_WIDTH  registered instruction.
- IFID_PCPlus4_o  output  DATA_WIDTH  registered PC+4 of that instruction.
- IFID_Valid_o  output  1  IF/ID holds a real instruction.
- Fault_o  output  1  sticky out-of-range fetch flag; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset (reset=0, asynchronous, any time):
  - PC=TEXT_BASE, so MemAddress_o=0.
  - IFID_Instruction_o=32'h0000_0000 (NOP), IFID_PCPlus4_o=0, IFID_Valid_o=0, Fault_o=0.
  - Deassertion takes effect at the next rising edge; the first fetch is at TEXT_BASE.
- PC update priority at each rising edge: Redirect_i > Stall_i > sequential.
  - Redirect: PC <= {Target_i[31:2],2'b00}. Misaligned low bits are silently cleared.
  - Stall (no redirect): PC holds.
  - Otherwise: PC <= PC+4, modulo 2^DATA_WIDTH. 32'hFFFF_FFFC wraps to 0 without a flag.
- IF/ID update at each rising edge, same priority:
  - Redirect: instruction=NOP, PCPlus4=0, Valid=0. This squashes the wrong-path fetch.
  - Stall: all IF/ID fields hold, including Valid.
  - Otherwise: instruction=Instruction_i, PCPlus4=PC+4, Valid=1.
- Redirect and Stall asserted together: redirect wins for both PC and IF/ID. The hazard unit must not depend on the stall being honoured in that cycle.
- Latency:
  - Address to IF/ID is one cycle.
  - Redirect issued in cycle N: target's instruction appears in IF/ID after edge N+2. Exactly one bubble (Valid=0) in between.
- Combinational outputs:
  - MemAddress_o = PC - TEXT_BASE, modulo 2^DATA_WIDTH.
  - PC_o is a direct register output.
- No combinational path from Stall_i or Redirect_i to MemAddress_o.

Optional Feature:
- Macro: FETCH_BOUNDS_CHECK_EN.
- Defined:
  - A fetch whose word index MemAddress_o[31:2] >= MEMORY_DEPTH, or whose PC < TEXT_BASE, loads IF/ID with NOP and Valid=0 instead of Instruction_i.
  - Fault_o is set on that edge and stays 1 until reset.
  - PC still advances normally; stall and redirect rules are unchanged.
- Undefined:
  - No range check; Instruction_i is captured unconditionally.
  - Fault_o is tied to 0.

Decomposition:
- Shared package: NOP_INSTR=32'h0, PC_INCREMENT=4, default TEXT_BASE and DATA_WIDTH constants.
- Sub-module pc_register: DATA_WIDTH-wide register with enable, reset value parameter, asynchronous active-low reset.
  - Instantiated once for PC (enable = Redirect_i | ~Stall_i).
  - IF/ID fields live in fetch_stage itself.

Test Plan:
- Reset release, no stall/redirect, ROM word k = 32'h1000_0000+k -> PC_o 0x00400000, 0x00400004, 0x00400008. IF/ID holds 0x10000000 with PCPlus4 0x00400004 after edge 1, Valid=1.
- Stall_i=1 for 3 cycles at PC 0x00400008 -> PC_o and IF/ID unchanged for 3 edges. Sequence resumes with no duplicated or skipped instruction.
- Redirect_i=1, Target_i=0x00400041 at PC 0x0040000C -> PC_o=0x00400040 next edge, IF/ID Valid=0 for one cycle. Then the word at index 16 appears with PCPlus4 0x00400044.
- Redirect_i and Stall_i both 1 -> redirect behaviour exactly as in the previous case.
- reset pulsed low mid-cycle while Valid=1 -> outputs reach reset values immediately, without waiting for a clock edge.
- With FETCH_BOUNDS_CHECK_EN and MEMORY_DEPTH=32: redirect to 0x00400080 -> IF/ID NOP with Valid=0, Fault_o=1 and sticky. Without the macro, Fault_o stays 0.
